// File: rtl/sync_fifo_thresh_pkg.sv
// Shared FIFO definitions: read-mode encodings and the ceil-log2 helper
// used to validate address widths at elaboration.
package sync_fifo_thresh_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DW register array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_mem #(
    parameter int DW     = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and standard or FWFT read mode.
module sync_fifo_thresh
    import sync_fifo_thresh_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [DW-1:0]   wr_data,
    input  logic            rd_en,
    input  logic            clr_err,
    output logic [DW-1:0]   rd_data,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
    localparam fifo_mode_e      MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("sync_fifo_thresh: DEPTH must equal 2**ADDR_W");
    end
    if (ADDR_W != clog2(DEPTH) || DEPTH < 4) begin : g_bad_addr_w
        $error("sync_fifo_thresh: ADDR_W inconsistent with DEPTH or DEPTH < 4");
    end
    if (AE_LEVEL >= AF_LEVEL || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0) begin : g_bad_levels
        $error("sync_fifo_thresh: threshold levels out of range");
    end

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_next;
    logic            full_q;
    logic            empty_q;
    logic            af_q;
    logic            ae_q;
    logic            ovf_q;
    logic            unf_q;
    logic            wr_acc;
    logic            rd_acc;
    logic [DW-1:0]   mem_rdata;

    // Accept decisions use the registered flags, so a full FIFO refuses a write
    // even when a read frees a slot in the same cycle (and vice versa for empty).
    always_comb begin
        wr_acc     = wr_en && !full_q;
        rd_acc     = rd_en && !empty_q;
        count_next = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + ONE_C;
            2'b01:   count_next = count_q - ONE_C;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
            count_q <= count_next;
            full_q  <= (count_next == DEPTH_C);
            empty_q <= (count_next == '0);
            af_q    <= (count_next >= AF_C);
            ae_q    <= (count_next <= AE_C);
        end
    end

    // An error set in the same cycle as clr_err takes priority over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rd_en && empty_q) begin
                unf_q <= 1'b1;
            end else if (clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(wr_data),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(mem_rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word presented combinationally; zero while empty keeps the
        // reset value clean even though it is don't-care there.
        assign rd_data = empty_q ? '0 : mem_rdata;
    end else begin : g_std
        logic [DW-1:0] rd_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= mem_rdata;
            end
        end

        assign rd_data = rd_data_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Pointer distance must always track the registered occupancy.
    a_ptr_count : assert property (@(posedge clk) disable iff (rst)
        (ADDR_W+1)'(wr_ptr - rd_ptr) == count_q);

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench: standard and FWFT instances share stimulus and are
// compared against a queue-based reference model.
module tb_sync_fifo_thresh;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          clr_err;

    logic [DW-1:0]   s_rd_data, f_rd_data;
    logic            s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic            f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [ADDR_W:0] s_count, f_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_std;
    logic          m_ovf;
    logic          m_unf;

    sync_fifo_thresh #(
        .DW(DW), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(s_rd_data), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_thresh #(
        .DW(DW), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(f_rd_data), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    // {full, empty, almost_full, almost_empty, count[4:0], overflow, underflow}
    function automatic logic [10:0] exp_stat();
        int n;
        n = q.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, 5'(n), m_ovf, m_unf};
    endfunction

    function automatic logic [10:0] s_stat();
        return {s_full, s_empty, s_af, s_ae, s_count, s_ovf, s_unf};
    endfunction

    function automatic logic [10:0] f_stat();
        return {f_full, f_empty, f_af, f_ae, f_count, f_ovf, f_unf};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_std = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic was_full;
        logic was_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r && !was_empty) m_std = q.pop_front();
        if (w && !was_full) q.push_back(d);
        if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (s_stat() !== 11'b01_01_00000_00 || f_stat() !== 11'b01_01_00000_00) begin
            failures++;
            $display("FAIL reset_status std=%b fwft=%b exp=%b", s_stat(), f_stat(), 11'b01_01_00000_00);
        end
        checks++;
        if (s_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=00", s_rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (s_stat() !== exp_stat() || f_stat() !== exp_stat()) begin
            failures++;
            $display("FAIL reset_idle std=%b fwft=%b exp=%b", s_stat(), f_stat(), exp_stat());
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (s_stat() !== exp_stat() || f_stat() !== exp_stat() || f_rd_data !== 8'h01) begin
                failures++;
                $display("FAIL fill i=%0d std=%b fwft=%b exp=%b fwft_head=%h exp_head=01",
                         i, s_stat(), f_stat(), exp_stat(), f_rd_data);
            end
        end
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (s_stat() !== exp_stat() || f_stat() !== exp_stat() || s_rd_data !== 8'(i)) begin
                failures++;
                $display("FAIL drain i=%0d std=%b fwft=%b exp=%b rd_data=%h exp_rd=%h",
                         i, s_stat(), f_stat(), exp_stat(), s_rd_data, 8'(i));
            end
            if (q.size() != 0) begin
                checks++;
                if (f_rd_data !== q[0]) begin
                    failures++;
                    $display("FAIL drain_fwft_head i=%0d got=%h exp=%h", i, f_rd_data, q[0]);
                end
            end
        end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if (s_ovf !== 1'b1 || s_count !== 5'd16 || s_stat() !== exp_stat()) begin
            failures++;
            $display("FAIL overflow_set ovf=%b count=%0d exp_ovf=1 exp_count=16", s_ovf, s_count);
        end
        drive(1'b1, 8'hBB, 1'b0, 1'b1);
        checks++;
        if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set_beats_clear std=%b fwft=%b exp=1", s_ovf, f_ovf);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (s_ovf !== 1'b0 || s_stat() !== exp_stat()) begin
            failures++;
            $display("FAIL overflow_clear ovf=%b exp=0 stat=%b exp_stat=%b", s_ovf, s_stat(), exp_stat());
        end
        drive(1'b1, 8'hCC, 1'b1, 1'b0);
        checks++;
        if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_rd_data !== 8'h80) begin
            failures++;
            $display("FAIL full_wr_rd count=%0d ovf=%b rd=%h exp 15/1/80", s_count, s_ovf, s_rd_data);
        end
        while (q.size() != 0) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (s_rd_data !== m_std || s_rd_data === 8'hAA || s_stat() !== exp_stat()) begin
                failures++;
                $display("FAIL overflow_drain rd=%h exp=%h stat=%b exp_stat=%b",
                         s_rd_data, m_std, s_stat(), exp_stat());
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (s_unf !== 1'b1 || f_unf !== 1'b1 || s_rd_data !== 8'h8F || s_count !== 5'd0) begin
            failures++;
            $display("FAIL underflow_set unf=%b/%b rd=%h count=%0d exp 1/1/8f/0",
                     s_unf, f_unf, s_rd_data, s_count);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (s_unf !== 1'b0 || s_stat() !== exp_stat()) begin
            failures++;
            $display("FAIL underflow_clear unf=%b exp=0", s_unf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            checks++;
            if (s_count !== 5'd8 || s_stat() !== exp_stat() || f_stat() !== exp_stat()
                || s_rd_data !== m_std || f_rd_data !== q[0]) begin
                failures++;
                $display("FAIL back_to_back i=%0d count=%0d rd=%h exp_rd=%h head=%h exp_head=%h",
                         i, s_count, s_rd_data, m_std, f_rd_data, q[0]);
            end
        end
    endtask

    task automatic test_fwft();
        do_reset();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++;
        if (f_empty !== 1'b0 || f_rd_data !== 8'h5A) begin
            failures++;
            $display("FAIL fwft_first_word empty=%b rd=%h exp 0/5a", f_empty, f_rd_data);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (f_rd_data !== 8'h5A) begin
            failures++;
            $display("FAIL fwft_hold rd=%h exp=5a", f_rd_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (f_empty !== 1'b1 || f_count !== 5'd0) begin
            failures++;
            $display("FAIL fwft_pop empty=%b count=%0d exp 1/0", f_empty, f_count);
        end
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if (f_stat() !== exp_stat() || f_unf !== 1'b1 || f_count !== 5'd1 || f_rd_data !== 8'h77) begin
            failures++;
            $display("FAIL empty_wr_rd stat=%b exp=%b rd=%h exp_rd=77", f_stat(), exp_stat(), f_rd_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (s_stat() !== 11'b01_01_00000_00 || f_stat() !== 11'b01_01_00000_00 || s_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL async_reset std=%b fwft=%b rd=%h exp=%b/00",
                     s_stat(), f_stat(), s_rd_data, 11'b01_01_00000_00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        checks++;
        if (f_rd_data !== 8'h33 || s_count !== 5'd1) begin
            failures++;
            $display("FAIL post_reset_write head=%h count=%0d exp 33/1", f_rd_data, s_count);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (s_rd_data !== 8'h33 || s_count !== 5'd0 || s_empty !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_read rd=%h count=%0d empty=%b exp 33/0/1", s_rd_data, s_count, s_empty);
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        int bias;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bias = (i / 50) % 2;
            w = ($urandom_range(0, 3) < (bias ? 3 : 1));
            r = ($urandom_range(0, 3) < (bias ? 1 : 3));
            c = ($urandom_range(0, 7) == 0);
            drive(w, 8'($urandom), r, c);
            checks++;
            if (s_stat() !== exp_stat() || f_stat() !== exp_stat() || s_rd_data !== m_std) begin
                failures++;
                $display("FAIL random i=%0d std=%b fwft=%b exp=%b rd=%h exp_rd=%h",
                         i, s_stat(), f_stat(), exp_stat(), s_rd_data, m_std);
            end
            if (q.size() != 0) begin
                checks++;
                if (f_rd_data !== q[0]) begin
                    failures++;
                    $display("FAIL random_fwft_head i=%0d got=%h exp=%h", i, f_rd_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        model_reset();
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_back_to_back();
        test_fwft();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
